ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch unit for the multicycle RV32 core. It samples the next-PC produced by the PC stage and issues one AXI-lite-style read to instruction memory. It then presents the fetched word, its PC and any fetch fault to decode over a valid/ready handshake. It sits between the PC stage and decode, and supports flush for trap/redirect.

Parameters:
TIMEOUT, 64, max cycles in DATA/DRAIN waiting for rvalid before declaring a timeout fault (>=2)
NOP_INST, 32'h00000013, word driven on inst when a fault is reported

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
pc  input  32  next fetch address from PC stage (dnpc)
flush  input  1  discard in-flight/pending fetch
araddr  output  32  read address
arvalid  output  1  read address valid
arready  input  1  read address accepted
rdata  input  32  read data
rresp  input  2  read response, nonzero = error
rvalid  input  1  read data valid
rready  output  1  read data ready
inst  output  32  fetched instruction
inst_pc  output  32  address of inst
inst_valid  output  1  inst/inst_pc/inst_fault valid to decode
inst_ready  input  1  decode accepts
inst_fault  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout

Behaviour:
- Reset is synchronous and active-low on rst_n; clock is clk. On reset: state IDLE; arvalid, rready and inst_valid = 0; araddr, inst, inst_pc = 0; inst_fault = 0; timeout counter = 0; hung flag = 0. Reset takes effect from any state, mid-transaction included.
- States: IDLE, ADDR, DATA, OUT, DRAIN. arvalid=1 only in ADDR; rready=1 only in DATA and DRAIN; inst_valid=1 only in OUT.
- IDLE:
  - flush=1: stay IDLE.
  - pc[1:0]!=0: inst_pc<=pc, inst<=NOP_INST, inst_fault<=1, go OUT. No bus request.
  - Otherwise: araddr<=pc, inst_pc<=pc, go ADDR.
  - pc must be stable in the IDLE sampling cycle.
- ADDR:
  - araddr and arvalid are held stable until arready; arvalid is never withdrawn.
  - On arready: counter<=0, then DATA, or DRAIN if a flush was seen in ADDR (latched drop flag).
- DATA:
  - rvalid=1: inst<=rdata and inst_fault<=0 if rresp==0; else inst<=NOP_INST, inst_fault<=2. Go OUT.
  - flush=1 with rvalid=1: discard the data, go IDLE.
  - flush=1 with rvalid=0: go DRAIN with counter cleared.
  - No rvalid: counter++. If counter==TIMEOUT-1: inst<=NOP_INST, inst_fault<=3, hung<=1, go OUT.
- OUT:
  - inst, inst_pc and inst_fault are stable while inst_valid=1 and !inst_ready.
  - On inst_ready, or on flush (flush has priority; the instruction is dropped): go DRAIN if hung (counter<=0, hung<=0), else IDLE.
- DRAIN:
  - Consumes and discards exactly one response: rvalid=1 -> IDLE.
  - Otherwise counter++; counter==TIMEOUT-1 -> IDLE, no fault reported.
  - flush in DRAIN is ignored.
- Latency with zero-wait memory (arready and rvalid asserted immediately):
  - IDLE sample at cycle 0, ADDR at 1, DATA at 2, inst_valid at 3.
  - If inst_ready is high at 3, IDLE at 4: one instruction per 4 cycles.
- At most one outstanding read. The counter is 6+ bits wide (clog2(TIMEOUT)) and saturates, never wraps.

Test Plan:
- Zero-wait fetch: pc=0x8000_0000, arready=1, rvalid=1, rdata=0x0010_0093, rresp=0 -> inst_valid in cycle 3 with inst=0x00100093, inst_pc=0x80000000, inst_fault=0; rready high only in cycle 2.
- Backpressure: arready held low 5 cycles, then rvalid 3 cycles late, inst_ready low 4 cycles -> araddr/arvalid stable 5 cycles; inst/inst_pc stable while inst_valid and !inst_ready; single handshake returns to IDLE.
- Misaligned pc=0x8000_0002 -> no arvalid ever; inst_valid next cycle with inst_fault=1, inst=0x00000013.
- Bus error rresp=2'b10 -> inst_fault=2, inst=0x00000013. Timeout with TIMEOUT=8 and rvalid never returned -> inst_fault=3 after 8 DATA cycles, then DRAIN lasts 8 cycles before IDLE.
- Flush in DATA, rvalid arrives 2 cycles later with 0xDEADBEEF -> word discarded, no inst_valid, returns to IDLE, next fetch uses new pc.
- Reset asserted in DATA mid-transaction -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// One read address channel and one read data channel, AXI-lite style.
interface ifu_fetch_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: samples the next PC, issues one instruction-memory read and hands the
// word, its PC and any fault to decode over valid/ready. Supports flush and read timeouts.
module ifu_fetch #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        flush,
   ifu_fetch_if.master bus,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [1:0]  inst_fault
);

   localparam int unsigned CntW = ($clog2(TIMEOUT) > 6) ? $clog2(TIMEOUT) : 6;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   localparam logic [1:0] FaultNone     = 2'd0;
   localparam logic [1:0] FaultMisalign = 2'd1;
   localparam logic [1:0] FaultBus      = 2'd2;
   localparam logic [1:0] FaultTimeout  = 2'd3;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StAddr  = 3'd1;
   localparam logic [2:0] StData  = 3'd2;
   localparam logic [2:0] StOut   = 3'd3;
   localparam logic [2:0] StDrain = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [31:0]     araddr_q, araddr_d;
   logic [31:0]     inst_q, inst_d;
   logic [31:0]     inst_pc_q, inst_pc_d;
   logic [1:0]      fault_q, fault_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            hung_q, hung_d;
   logic            drop_q, drop_d;

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;
      cnt_d     = cnt_q;
      hung_d    = hung_q;
      drop_d    = drop_q;

      case (state_q)
         StIdle: begin
            if (!flush) begin
               inst_pc_d = pc;
               if (pc[1:0] != 2'b00) begin
                  inst_d  = NOP_INST;
                  fault_d = FaultMisalign;
                  state_d = StOut;
               end else begin
                  araddr_d = pc;
                  state_d  = StAddr;
               end
            end
         end
         StAddr: begin
            // arvalid cannot be withdrawn, so a flush here only marks the response for discard
            if (flush) drop_d = 1'b1;
            if (bus.arready) begin
               cnt_d   = '0;
               drop_d  = 1'b0;
               state_d = (drop_q || flush) ? StDrain : StData;
            end
         end
         StData: begin
            if (flush) begin
               cnt_d   = '0;
               state_d = bus.rvalid ? StIdle : StDrain;
            end else if (bus.rvalid) begin
               if (bus.rresp == 2'b00) begin
                  inst_d  = bus.rdata;
                  fault_d = FaultNone;
               end else begin
                  inst_d  = NOP_INST;
                  fault_d = FaultBus;
               end
               state_d = StOut;
            end else if (cnt_q == CntLast) begin
               inst_d  = NOP_INST;
               fault_d = FaultTimeout;
               hung_d  = 1'b1;
               state_d = StOut;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StOut: begin
            if (flush || inst_ready) begin
               // A timed-out read may still answer later; soak it up before the next request
               if (hung_q) begin
                  cnt_d   = '0;
                  hung_d  = 1'b0;
                  state_d = StDrain;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StDrain: begin
            if (bus.rvalid || cnt_q == CntLast) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         araddr_q  <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         fault_q   <= FaultNone;
         cnt_q     <= '0;
         hung_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
         cnt_q     <= cnt_d;
         hung_q    <= hung_d;
         drop_q    <= drop_d;
      end
   end

   assign bus.araddr  = araddr_q;
   assign bus.arvalid = (state_q == StAddr);
   assign bus.rready  = (state_q == StData) || (state_q == StDrain);
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign inst_fault  = fault_q;
   assign inst_valid  = (state_q == StOut);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written flush/timeout/reset
// sequences and randomized fetches against a transaction-level reference model.
module tb_ifu_fetch;
   localparam int          TO  = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        flush;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  inst_fault;

   ifu_fetch_if bus ();

   ifu_fetch #(
      .TIMEOUT (TO),
      .NOP_INST(NOP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc        (pc),
      .flush     (flush),
      .bus       (bus),
      .inst      (inst),
      .inst_pc   (inst_pc),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_fault(inst_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      int          ad;
      int          rd;
      logic [31:0] data;
      logic [1:0]  resp;
      int          readyd;
      logic [31:0] e_inst;
      logic [1:0]  e_fault;
      int          e_lat;
      int          e_arc;
      int          e_rc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One fetch from IDLE: memory accepts after ad extra cycles, answers after rd extra rready
   // cycles (rd >= 255 means never), decode accepts after readyd extra valid cycles.
   task automatic run_fetch(input logic [31:0] p, input int ad, input int rd,
                            input logic [31:0] data, input logic [1:0] resp, input int readyd,
                            output logic [31:0] o_inst, output logic [31:0] o_pc,
                            output logic [1:0] o_fault, output int lat, output int arc,
                            output int rc, output int unstable);
      int vseen;
      bit done;
      vseen = 0; done = 0; lat = -1; arc = 0; rc = 0; unstable = 0;
      o_inst = 'x; o_pc = 'x; o_fault = 'x;
      flush = 1'b0;
      pc    = p;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         bus.arready = 1'b0;
         bus.rvalid  = 1'b0;
         bus.rdata   = $urandom;
         bus.rresp   = 2'($urandom);
         inst_ready  = 1'b0;
         if (cyc == 1) pc = $urandom;
         if (bus.arvalid) begin
            if (bus.araddr !== p) unstable++;
            bus.arready = (arc == ad);
            arc++;
         end
         if (bus.rready) begin
            bus.rvalid = (rc == rd);
            if (bus.rvalid) begin
               bus.rdata = data;
               bus.rresp = resp;
            end
            rc++;
         end
         if (inst_valid) begin
            if (vseen == 0) begin
               lat = cyc; o_inst = inst; o_pc = inst_pc; o_fault = inst_fault;
            end else if (inst !== o_inst || inst_pc !== o_pc || inst_fault !== o_fault) begin
               unstable++;
            end
            inst_ready = (vseen == readyd);
            done = inst_ready;
            vseen++;
         end
         step();
      end
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      inst_ready  = 1'b0;
      flush       = 1'b1;
   endtask

   // Counts DRAIN cycles; the discarded response arrives on drain cycle dd (never if dd >= 255).
   task automatic drain(input int dd, output int len, output int saw_valid);
      len = 0; saw_valid = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (inst_valid) saw_valid++;
         if (!bus.rready) break;
         bus.rvalid = (len == dd);
         bus.rdata  = 32'hBAD0_BAD0;
         len++;
         step();
      end
      bus.rvalid = 1'b0;
   endtask

   // Fetch outcome from the behavioural rules: address/data wait counts in, fault and timing out.
   task automatic model(input logic [31:0] p, input int ad, input int rd, input logic [31:0] d,
                        input logic [1:0] r, output logic [31:0] ei, output logic [1:0] ef,
                        output int el, output int ea, output int er, output bit hung);
      hung = 0;
      if (p[1:0] != 2'b00) begin
         ei = NOP; ef = 2'd1; el = 1; ea = 0; er = 0;
      end else if (rd >= TO) begin
         ei = NOP; ef = 2'd3; el = 2 + ad + TO; ea = ad + 1; er = TO; hung = 1;
      end else begin
         ei = (r == 2'b00) ? d : NOP;
         ef = (r == 2'b00) ? 2'd0 : 2'd2;
         el = 3 + ad + rd; ea = ad + 1; er = rd + 1;
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_arvalid"}, 32'(bus.arvalid), 32'd0);
      chk({name, "_rready"}, 32'(bus.rready), 32'd0);
      chk({name, "_inst_valid"}, 32'(inst_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] o_inst, o_pc, e_inst, rp;
      logic [1:0]  o_fault, e_fault, rresp_r;
      int lat, arc, rc, unst, e_lat, e_arc, e_rc, len, sawv, rr, ad, rd, rdy, dd;
      bit hung;

      vecs[0] = '{32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 0, 32'h0010_0093, 2'd0, 3, 1, 1};
      vecs[1] = '{32'h8000_0004, 5, 3, 32'h0000_0297, 2'b00, 4, 32'h0000_0297, 2'd0, 11, 6, 4};
      vecs[2] = '{32'h8000_0002, 0, 0, 32'h1111_1111, 2'b00, 0, NOP, 2'd1, 1, 0, 0};
      vecs[3] = '{32'h8000_0008, 0, 0, 32'h1234_5678, 2'b10, 0, NOP, 2'd2, 3, 1, 1};
      vecs[4] = '{32'h0000_0100, 1, 2, 32'hCAFE_F00D, 2'b01, 2, NOP, 2'd2, 6, 2, 3};
      vecs[5] = '{32'h0000_0011, 3, 0, 32'h2222_2222, 2'b00, 1, NOP, 2'd1, 1, 0, 0};
      vecs[6] = '{32'h0000_0000, 2, 0, 32'hFFFF_FFFF, 2'b00, 1, 32'hFFFF_FFFF, 2'd0, 5, 3, 1};
      vecs[7] = '{32'h7FFF_FFFC, 0, 4, 32'h0000_0000, 2'b11, 0, NOP, 2'd2, 7, 1, 5};

      rst_n = 1'b0; flush = 1'b1; pc = 32'h8000_0000; inst_ready = 1'b0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
      step(); step();
      chk_idle("reset");
      chk("reset_araddr", bus.araddr, 32'd0);
      chk("reset_inst", inst, 32'd0);
      chk("reset_inst_pc", inst_pc, 32'd0);
      chk("reset_fault", 32'(inst_fault), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         run_fetch(vecs[i].pc, vecs[i].ad, vecs[i].rd, vecs[i].data, vecs[i].resp,
                   vecs[i].readyd, o_inst, o_pc, o_fault, lat, arc, rc, unst);
         chk($sformatf("v%0d_inst", i), o_inst, vecs[i].e_inst);
         chk($sformatf("v%0d_inst_pc", i), o_pc, vecs[i].pc);
         chk($sformatf("v%0d_fault", i), 32'(o_fault), 32'(vecs[i].e_fault));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
         chk($sformatf("v%0d_ar_cycles", i), 32'(arc), 32'(vecs[i].e_arc));
         chk($sformatf("v%0d_r_cycles", i), 32'(rc), 32'(vecs[i].e_rc));
         chk($sformatf("v%0d_stable", i), 32'(unst), 32'd0);
         step();
         chk_idle($sformatf("v%0d_after", i));
      end

      // Timeout, then DRAIN runs its full length with no response
      run_fetch(32'h8000_0010, 0, 255, 32'h0, 2'b00, 1, o_inst, o_pc, o_fault, lat, arc, rc, unst);
      chk("to_fault", 32'(o_fault), 32'd3);
      chk("to_inst", o_inst, NOP);
      chk("to_latency", 32'(lat), 32'd10);
      chk("to_r_cycles", 32'(rc), 32'd8);
      drain(255, len, sawv);
      chk("to_drain_len", 32'(len), 32'd8);
      chk("to_drain_valid", 32'(sawv), 32'd0);
      chk_idle("to_after");

      // Timeout, late response consumed by DRAIN on its fourth cycle
      run_fetch(32'h8000_0014, 1, 255, 32'h0, 2'b00, 0, o_inst, o_pc, o_fault, lat, arc, rc, unst);
      chk("to2_fault", 32'(o_fault), 32'd3);
      drain(3, len, sawv);
      chk("to2_drain_len", 32'(len), 32'd4);
      chk_idle("to2_after");

      // Flush in DATA; response two cycles later is discarded
      flush = 1'b0; pc = 32'h8000_0020; rr = 0; sawv = 0;
      step();
      pc = $urandom; bus.arready = 1'b1;
      step();
      bus.arready = 1'b0; flush = 1'b1; rr += int'(bus.rready); sawv += int'(inst_valid);
      step();
      rr += int'(bus.rready); sawv += int'(inst_valid);
      step();
      rr += int'(bus.rready); sawv += int'(inst_valid);
      bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b00;
      step();
      bus.rvalid = 1'b0; sawv += int'(inst_valid);
      chk("fd_rready_cycles", 32'(rr), 32'd3);
      chk("fd_no_valid", 32'(sawv), 32'd0);
      chk_idle("fd_after");
      run_fetch(32'h8000_0040, 0, 0, 32'h0040_0113, 2'b00, 0, o_inst, o_pc, o_fault, lat, arc,
                rc, unst);
      chk("fd_next_inst", o_inst, 32'h0040_0113);
      chk("fd_next_pc", o_pc, 32'h8000_0040);
      chk("fd_next_latency", 32'(lat), 32'd3);

      // Flush seen in ADDR before arready; the flag must outlive the flush pulse
      flush = 1'b0; pc = 32'h8000_0080;
      step();
      flush = 1'b1; pc = $urandom;
      step();
      flush = 1'b0;
      chk("fa_arvalid_held", 32'(bus.arvalid), 32'd1);
      chk("fa_araddr_held", bus.araddr, 32'h8000_0080);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0; flush = 1'b1;
      chk("fa_drain_rready", 32'(bus.rready), 32'd1);
      chk("fa_no_valid", 32'(inst_valid), 32'd0);
      bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
      step();
      bus.rvalid = 1'b0;
      chk_idle("fa_after");

      // Flush while presenting an instruction drops it
      flush = 1'b0; pc = 32'h8000_0103;
      step();
      chk("fo_valid", 32'(inst_valid), 32'd1);
      flush = 1'b1;
      step();
      chk("fo_dropped", 32'(inst_valid), 32'd0);

      // Reset mid-transaction in DATA
      flush = 1'b0; pc = 32'h8000_0200;
      step();
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0; rst_n = 1'b0;
      step();
      chk_idle("rst_data");
      chk("rst_araddr", bus.araddr, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_fault", 32'(inst_fault), 32'd0);
      rst_n = 1'b1; flush = 1'b1;
      run_fetch(32'h8000_0300, 0, 0, 32'h0000_0513, 2'b00, 0, o_inst, o_pc, o_fault, lat, arc,
                rc, unst);
      chk("rst_next_latency", 32'(lat), 32'd3);
      chk("rst_next_inst", o_inst, 32'h0000_0513);

      for (int i = 0; i < 40; i++) begin
         rp = $urandom;
         if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
         ad  = $urandom_range(0, 4);
         rd  = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 5);
         rdy = $urandom_range(0, 3);
         rresp_r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         o_inst = $urandom;
         model(rp, ad, rd, o_inst, rresp_r, e_inst, e_fault, e_lat, e_arc, e_rc, hung);
         run_fetch(rp, ad, rd, o_inst, rresp_r, rdy, o_inst, o_pc, o_fault, lat, arc, rc, unst);
         chk($sformatf("rnd%0d_inst", i), o_inst, e_inst);
         chk($sformatf("rnd%0d_pc", i), o_pc, rp);
         chk($sformatf("rnd%0d_fault", i), 32'(o_fault), 32'(e_fault));
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
         chk($sformatf("rnd%0d_ar_cycles", i), 32'(arc), 32'(e_arc));
         chk($sformatf("rnd%0d_r_cycles", i), 32'(rc), 32'(e_rc));
         chk($sformatf("rnd%0d_stable", i), 32'(unst), 32'd0);
         if (hung) begin
            dd = $urandom_range(0, 10);
            drain(dd, len, sawv);
            chk($sformatf("rnd%0d_drain_len", i), 32'(len), 32'((dd + 1 < TO) ? dd + 1 : TO));
         end
         chk_idle($sformatf("rnd%0d_after", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
